shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_multiplier.sv | 172 +++++++++++++++++
 tb/tb_shift_add_multiplier.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
//
// Purpose:
//   Multi-cycle shift-and-add multiplier for signed or unsigned operands.
//   - The operands are converted to unsigned magnitudes when accepted.
//   - One multiplier bit is processed per clock, LSB first, into a
//     2*WIDTH-bit accumulator.
//   - A FIXUP state applies the result sign.
//   - The result is then presented in DONE until start is released.
//
// Parameters:
//   WIDTH         operand width, 2..32 (default 12)
//
// Ports:
//   clock         sole clock, rising edge
//   reset         asynchronous, active-high reset
//   start         level request; accepted when high in IDLE
//   signed_mode   1 = two's-complement operands/product, 0 = unsigned
//   multiplier    operand A, sampled only at accept
//   multiplicand  operand B, sampled only at accept
//   product       registered 2*WIDTH-bit result
//   busy          high in CALC and FIXUP
//   finished      high in DONE only
//
// Configuration:
//   MULT_EARLY_EXIT_EN  when defined, CALC ends as soon as the remaining
//                       multiplier-magnitude bits are all zero.
//                       FIXUP then right-aligns the accumulator by the
//                       number of skipped bits.
// -----------------------------------------------------------------------------
module shift_add_multiplier #(
    parameter int WIDTH = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               finished
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_q, neg_d;
`ifdef MULT_EARLY_EXIT_EN
    logic [CNT_W-1:0]   shift_q, shift_d;
`endif

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mag;

    // Magnitude of an operand; the most-negative value maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sm);
        return (sm && v[WIDTH-1]) ? (WIDTH'(0) - v) : v;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        mcand_d   = mcand_q;
        neg_d     = neg_q;
`ifdef MULT_EARLY_EXIT_EN
        shift_d   = shift_q;
`endif
        sum       = '0;
        mag       = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mplier_d = magnitude(multiplier, signed_mode);
                    mcand_d  = magnitude(multiplicand, signed_mode);
                    neg_d    = signed_mode & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end

            CALC: begin
                // Add into the upper half with carry kept, then shift the
                // accumulator right.  The carry lands in the MSB and the
                // finished low bit enters the lower half.
                sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                         + {1'b0, (mplier_q[0] ? mcand_q : '0)};
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
`ifdef MULT_EARLY_EXIT_EN
                if (cnt_q == LAST || mplier_d == '0) begin
                    state_d = FIXUP;
                    shift_d = LAST - cnt_q;
                end
`else
                if (cnt_q == LAST) begin
                    state_d = FIXUP;
                end
`endif
            end

            FIXUP: begin
`ifdef MULT_EARLY_EXIT_EN
                // Skipped iterations would only have shifted; do it at once.
                mag = acc_q >> shift_q;
`else
                mag = acc_q;
`endif
                product_d = neg_q ? ((2*WIDTH)'(0) - mag) : mag;
                state_d   = DONE;
            end

            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Working datapath registers are always written before use after accept.
    always_ff @(posedge clock) begin
        acc_q    <= acc_d;
        mplier_q <= mplier_d;
        mcand_q  <= mcand_d;
        neg_q    <= neg_d;
`ifdef MULT_EARLY_EXIT_EN
        shift_q  <= shift_d;
`endif
    end

    assign product  = product_q;
    assign busy     = (state_q == CALC) || (state_q == FIXUP);
    assign finished = (state_q == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

    localparam int W = 12;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   multiplier;
    logic [W-1:0]   multiplicand;
    logic [2*W-1:0] product;
    logic           busy;
    logic           finished;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .product      (product),
        .busy         (busy),
        .finished     (finished)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Wait (bounded) for finished; returns edges waited, optionally
    // scrambling operand inputs while the operation runs.
    task automatic wait_done(input bit scramble, output int n);
        n = 0;
        while (!finished && n < 40) begin
            if (scramble) begin
                multiplier   = 12'($urandom);
                multiplicand = 12'($urandom);
                signed_mode  = 1'($urandom);
                start        = 1'($urandom);
            end
            @(posedge clock); #1;
            n++;
        end
        start = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sm, input logic [2*W-1:0] exp, input bit scramble);
        int n;
        @(negedge clock);
        start = 1'b1; multiplier = a; multiplicand = b; signed_mode = sm;
        @(posedge clock); #1;
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(scramble, n);
        chk({tag, "_lat"}, 32'(n), 32'd13);
        chk({tag, "_prod"}, 32'(product), 32'(exp));
        @(posedge clock); #1;   // DONE -> IDLE with start low
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; signed_mode = 1'b0;
        multiplier = '0; multiplicand = '0;
        #1;
        chk("rst_prod", 32'(product), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fin", 32'(finished), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("idle_nostart_busy", 32'(busy), 32'd0);

        do_op("u_fff_fff", 12'hFFF, 12'hFFF, 1'b0, 24'hFFE001, 1'b0);
        do_op("s_3_m5",    12'h003, 12'hFFB, 1'b1, 24'hFFFFF1, 1'b0);
        do_op("s_min_min", 12'h800, 12'h800, 1'b1, 24'h400000, 1'b0);
        do_op("s_m1_m1",   12'hFFF, 12'hFFF, 1'b1, 24'h000001, 1'b0);
        do_op("s_max_min", 12'h7FF, 12'h800, 1'b1, 24'hC00800, 1'b0);
        do_op("s_min_1",   12'h800, 12'h001, 1'b1, 24'hFFF800, 1'b0);
        do_op("u_zero",    12'h000, 12'hABC, 1'b0, 24'h000000, 1'b0);
        do_op("u_800_2",   12'h800, 12'h002, 1'b0, 24'h001000, 1'b0);
        do_op("u_scramble", 12'h123, 12'h010, 1'b0, 24'h001230, 1'b1);
        do_op("s_scramble", 12'hFFE, 12'h005, 1'b1, 24'hFFFFF6, 1'b1);

        // start held high through DONE: no retrigger
        @(negedge clock);
        start = 1'b1; multiplier = 12'd5; multiplicand = 12'd6; signed_mode = 1'b0;
        @(posedge clock); #1;
        n = 0;
        while (!finished && n < 40) begin @(posedge clock); #1; n++; end
        chk("hold_lat", 32'(n), 32'd13);
        multiplier = 12'd2; multiplicand = 12'd3;
        repeat (5) @(posedge clock);
        #1;
        chk("hold_fin", 32'(finished), 32'd1);
        chk("hold_busy", 32'(busy), 32'd0);
        chk("hold_prod", 32'(product), 32'h1E);
        @(negedge clock); start = 1'b0;
        @(negedge clock); start = 1'b1;      // one low edge, back to IDLE
        @(posedge clock); #1;                 // accept 2 x 3
        chk("retrig_busy", 32'(busy), 32'd1);
        repeat (5) @(posedge clock);
        #1;
        chk("retrig_prev_held", 32'(product), 32'h1E);
        start = 1'b0;
        wait_done(1'b0, n);
        chk("retrig_prod", 32'(product), 32'h6);
        @(posedge clock); #1;

        // reset mid-CALC
        @(negedge clock);
        start = 1'b1; multiplier = 12'hFFF; multiplicand = 12'hFFF; signed_mode = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_prod", 32'(product), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_fin", 32'(finished), 32'd0);
        @(negedge clock); reset = 1'b0;
        repeat (15) @(posedge clock);
        #1;
        chk("midrst_no_result", 32'(product), 32'd0);
        do_op("after_rst", 12'h00C, 12'h00D, 1'b0, 24'h00009C, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
